// File: rtl/led_scan_scheduler_pkg.sv
// Shared constants and types for the LED matrix / 7-segment scan scheduler.
package scan_pkg;

    localparam int NUM_ROWS = 8;
    localparam logic [7:0] COL_OFF = 8'hFF;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    // Segment order {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] COM_ONES = 4'b1110;
    localparam logic [3:0] COM_TENS = 4'b1101;
    localparam logic [3:0] COM_OFF  = 4'b1111;

endpackage

// File: rtl/led_scan_scheduler_seg7_decode.sv
// BCD digit to active-low 7-segment code; non-decimal inputs show blank.
module seg7_decode
    import scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_scan_scheduler.sv
// Double-buffered 8x8 RGB matrix row scanner with blanking gaps, frame-boundary
// buffer swaps and a two-digit 7-segment mux stepped with the row scan.
module led_scan_scheduler
    import scan_pkg::*;
#(
    parameter int DRIVE_CYCLES = 25000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       fb_wr_en,
    input  logic [2:0] fb_wr_row,
    input  logic [7:0] fb_wr_r,
    input  logic [7:0] fb_wr_g,
    input  logic [7:0] fb_wr_b,
    input  logic       fb_commit,
    output logic       fb_commit_ack,
    input  logic [3:0] digit_lo,
    input  logic [3:0] digit_hi,
    output logic [2:0] row_sel,
    output logic       row_en,
    output logic [7:0] col_r,
    output logic [7:0] col_g,
    output logic [7:0] col_b,
    output logic [6:0] seg,
    output logic [3:0] com,
    output logic       frame_start
);

    localparam int CNT_MAX = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             front_sel;
    logic             commit_pending;
    logic             digit_sel;
    logic [23:0]      bank [2][NUM_ROWS];

    logic        blank_done;
    logic        drive_done;
    logic        frame_edge;
    logic        swap;
    logic [3:0]  digit_mux;
    logic [6:0]  seg_next;
    logic [23:0] front_row;

    assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    assign drive_done = (state == DRIVE) && (cnt == DRIVE_LAST);
    assign frame_edge = drive_done && (row_sel == 3'd7);
    assign swap       = frame_edge && (commit_pending || fb_commit);
    assign digit_mux  = digit_sel ? digit_hi : digit_lo;
    assign front_row  = bank[front_sel][row_sel];

    seg7_decode u_seg7_decode (
        .digit (digit_mux),
        .seg   (seg_next)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= BLANK;
            cnt            <= '0;
            row_sel        <= '0;
            front_sel      <= 1'b0;
            commit_pending <= 1'b0;
            digit_sel      <= 1'b0;
            row_en         <= 1'b0;
            col_r          <= COL_OFF;
            col_g          <= COL_OFF;
            col_b          <= COL_OFF;
            seg            <= SEG_BLANK;
            com            <= COM_OFF;
            fb_commit_ack  <= 1'b0;
            frame_start    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    bank[b][r] <= '1;
                end
            end
        end else begin
            fb_commit_ack <= swap;
            frame_start   <= frame_edge;

            // Uses the pre-swap front_sel, so a write in the swap cycle lands in the new front frame
            if (fb_wr_en) begin
                bank[~front_sel][fb_wr_row] <= {fb_wr_r, fb_wr_g, fb_wr_b};
            end

            if (swap) begin
                front_sel      <= ~front_sel;
                commit_pending <= 1'b0;
            end else if (fb_commit) begin
                commit_pending <= 1'b1;
            end

            case (state)
                BLANK: begin
                    if (blank_done) begin
                        state     <= DRIVE;
                        cnt       <= '0;
                        row_en    <= 1'b1;
                        {col_r, col_g, col_b} <= front_row;
                        com       <= digit_sel ? COM_TENS : COM_ONES;
                        seg       <= seg_next;
                        digit_sel <= ~digit_sel;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (drive_done) begin
                        state   <= BLANK;
                        cnt     <= '0;
                        row_sel <= row_sel + 3'd1;
                        row_en  <= 1'b0;
                        col_r   <= COL_OFF;
                        col_g   <= COL_OFF;
                        col_b   <= COL_OFF;
                        com     <= COM_OFF;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
